// File: rtl/audio_pkg.sv
// Shared audio clocking definitions: reset-sequencer state encoding and default timing.
package audio_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    REL_CODEC = 3'd2,
    REL_I2S   = 3'd3,
    RUN       = 3'd4
  } seq_state_t;

  localparam int AUDIO_LOCK_FILTER    = 4;
  localparam int AUDIO_MIN_RST_CYCLES = 16;
  localparam int AUDIO_STAGE_GAP      = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/audio_sync_bit.sv
// Two-flop synchroniser for a single asynchronous level, cleared by the async active-low reset.
module audio_sync_bit (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_ff;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_ff <= 2'b00;
    else         sync_ff <= {sync_ff[0], d};
  end

  assign q = sync_ff[1];

endmodule

// File: rtl/audio_reset_sequencer.sv
// Staged audio reset controller: waits for a filtered MMCM lock plus a hold time, then releases
// codec, I2S and mixer resets in order; supports a software re-sequence with a completion ack.
module audio_reset_sequencer
  import audio_pkg::*;
#(
  parameter int LOCK_FILTER    = AUDIO_LOCK_FILTER,
  parameter int MIN_RST_CYCLES = AUDIO_MIN_RST_CYCLES,
  parameter int STAGE_GAP      = AUDIO_STAGE_GAP
) (
  input  logic clk,
  input  logic resetn,
  input  logic locked,
  input  logic soft_rst_req,
  output logic soft_rst_ack,
  output logic rst_codec,
  output logic rstn_codec,
  output logic rst_i2s,
  output logic rstn_i2s,
  output logic rst_mix,
  output logic rstn_mix,
  output logic ready
);

  localparam int CW = $clog2(max3(MIN_RST_CYCLES, STAGE_GAP, LOCK_FILTER) + 1);

  logic          locked_s;
  logic [CW-1:0] filt_cnt;
  logic [CW-1:0] cnt;
  logic          lock_ok;
  logic          req_d;
  logic          pending;
  logic          soft_edge;
  seq_state_t    state;

  audio_sync_bit u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (locked),
    .q      (locked_s)
  );

  // Saturating run-length of synchronised lock; any low sample restarts the filter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                           filt_cnt <= '0;
    else if (!locked_s)                    filt_cnt <= '0;
    else if (filt_cnt != CW'(LOCK_FILTER)) filt_cnt <= filt_cnt + 1'b1;
  end

  assign lock_ok   = (filt_cnt == CW'(LOCK_FILTER));
  assign soft_edge = soft_rst_req & ~req_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      req_d        <= 1'b0;
      pending      <= 1'b0;
      soft_rst_ack <= 1'b0;
      rst_codec    <= 1'b1;
      rst_i2s      <= 1'b1;
      rst_mix      <= 1'b1;
      ready        <= 1'b0;
    end else begin
      req_d        <= soft_rst_req;
      soft_rst_ack <= 1'b0;
      // Lock loss outranks everything, including a soft request seen on the same cycle.
      if (state != WAIT_LOCK && !locked_s) begin
        state     <= WAIT_LOCK;
        cnt       <= '0;
        pending   <= 1'b0;
        rst_codec <= 1'b1;
        rst_i2s   <= 1'b1;
        rst_mix   <= 1'b1;
        ready     <= 1'b0;
      end else begin
        case (state)
          WAIT_LOCK: begin
            if (lock_ok) begin
              state <= HOLD;
              cnt   <= '0;
            end
          end
          HOLD: begin
            if (cnt == CW'(MIN_RST_CYCLES - 1)) begin
              state     <= REL_CODEC;
              cnt       <= '0;
              rst_codec <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REL_CODEC: begin
            if (cnt == CW'(STAGE_GAP - 1)) begin
              state   <= REL_I2S;
              cnt     <= '0;
              rst_i2s <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REL_I2S: begin
            if (cnt == CW'(STAGE_GAP - 1)) begin
              state        <= RUN;
              cnt          <= '0;
              rst_mix      <= 1'b0;
              ready        <= 1'b1;
              soft_rst_ack <= pending;
              pending      <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            if (soft_edge) begin
              state     <= HOLD;
              cnt       <= '0;
              pending   <= 1'b1;
              rst_codec <= 1'b1;
              rst_i2s   <= 1'b1;
              rst_mix   <= 1'b1;
              ready     <= 1'b0;
            end
          end
          default: begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            pending   <= 1'b0;
            rst_codec <= 1'b1;
            rst_i2s   <= 1'b1;
            rst_mix   <= 1'b1;
            ready     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rstn_codec = ~rst_codec;
  assign rstn_i2s   = ~rst_i2s;
  assign rstn_mix   = ~rst_mix;

endmodule
